// File: rtl/delay_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : delay_pkg                                                 |
// | Brief    : Mode and state encodings shared by the delay timer.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package delay_pkg;

  localparam logic [1:0] MODE_HOLD     = 2'd0;
  localparam logic [1:0] MODE_PULSE    = 2'd1;
  localparam logic [1:0] MODE_PERIODIC = 2'd2;
  localparam logic [1:0] MODE_RETRIG   = 2'd3;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] S_COUNT    = 2'd1;
  localparam logic [STATE_W-1:0] S_WAIT_LOW = 2'd2;

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : edge_detect                                               |
// | Brief    : Rising-edge detector against a registered previous value. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/delay_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : delay_timer                                               |
// | Brief    : Counts N enabled ticks after a trigger, then expires in   |
// |            one of four modes (hold, pulse, periodic, retrigger).     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module delay_timer
  import delay_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] N,
  input  logic [1:0]       mode,
  input  logic             tick,
  input  logic             trigger,
  input  logic             abort,
  output logic             time_out,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   n_eff_q, n_eff_d, n_eff_in;
  logic [1:0]         mode_q, mode_d;
  logic               time_out_q, time_out_d;
  logic               armed_q, armed_d;
  logic               trig_rise, start, restart, expire;

  edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (trigger),
    .rise_o (trig_rise)
  );

  assign n_eff_in = (N == '0) ? CNT_ONE : N;
  assign start    = (state_q == S_IDLE) && trigger && armed_q;
  assign restart  = (state_q == S_COUNT) && (mode_q == MODE_RETRIG) && trig_rise;
  // A retrigger edge suppresses expiry in the same cycle.
  assign expire   = (state_q == S_COUNT) && tick && !restart &&
                    (count_q == n_eff_q - CNT_ONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (start) state_d = S_COUNT;
        S_COUNT: begin
          if (expire) begin
            if (mode_q == MODE_PERIODIC) state_d = trigger ? S_COUNT : S_IDLE;
            else                         state_d = S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: if (!trigger) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d    = count_q;
    time_out_d = 1'b0;
    n_eff_d    = n_eff_q;
    mode_d     = mode_q;
    armed_d    = armed_q;
    // After an abort a held trigger must drop before another run may start.
    if (abort) begin
      count_d = '0;
      armed_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          count_d = '0;
          if (!trigger) armed_d = 1'b1;
          if (start) begin
            n_eff_d = n_eff_in;
            mode_d  = mode;
          end
        end
        S_COUNT: begin
          if (restart) begin
            count_d = '0;
            n_eff_d = n_eff_in;
          end else if (expire) begin
            time_out_d = 1'b1;
            if (mode_q == MODE_PERIODIC) count_d = '0;
          end else if (tick) begin
            count_d = count_q + CNT_ONE;
          end
        end
        S_WAIT_LOW: begin
          if (trigger) time_out_d = (mode_q == MODE_HOLD) && time_out_q;
          else         count_d    = '0;
        end
        default: count_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      time_out_q <= 1'b0;
      n_eff_q    <= '0;
      mode_q     <= 2'd0;
      armed_q    <= 1'b1;
    end else begin
      count_q    <= count_d;
      time_out_q <= time_out_d;
      n_eff_q    <= n_eff_d;
      mode_q     <= mode_d;
      armed_q    <= armed_d;
    end
  end

  assign time_out = time_out_q;
  assign busy     = (state_q == S_COUNT);
  assign count    = count_q;

endmodule
`default_nettype wire
